// File: rtl/store_align_unit.sv
// Store alignment unit: places SB/SH/SW data into byte lanes and generates write strobes.
// Boundary-crossing stores are split into two word-aligned write beats.
module store_align_unit #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Req_Valid,
    output logic                    Req_Ready,
    input  logic [2:0]              Req_Funct3,
    input  logic [DATA_WIDTH-1:0]   Req_Addr,
    input  logic [DATA_WIDTH-1:0]   Req_Data,
    output logic                    Mem_W_Valid,
    input  logic                    Mem_W_Ready,
    output logic [DATA_WIDTH-1:0]   Mem_W_Addr,
    output logic [DATA_WIDTH-1:0]   Mem_W_Data,
    output logic [3:0]              Mem_W_Strb,
    output logic                    Store_Done,
    output logic                    Store_Err
);

    localparam int unsigned NB = 4;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND_LO = 2'd1;
    localparam logic [1:0] S_SEND_HI = 2'd2;

    logic [1:0]              state_q,   state_d;
    logic                    valid_q,   valid_d;
    logic [DATA_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic [NB-1:0]           strb_q,    strb_d;
    logic [DATA_WIDTH-1:0]   hi_addr_q, hi_addr_d;
    logic [DATA_WIDTH-1:0]   hi_data_q, hi_data_d;
    logic [NB-1:0]           hi_strb_q, hi_strb_d;
    logic                    hi_pend_q, hi_pend_d;
    logic                    done_q,    done_d;
    logic                    err_q,     err_d;

    logic [NB-1:0]           byte_mask;
    logic                    f3_ok;
    logic [DATA_WIDTH-1:0]   masked;
    logic [2*DATA_WIDTH-1:0] shifted;
    logic [2*NB-1:0]         strobe8;
    logic [DATA_WIDTH-1:0]   lo_addr;
    logic                    split;

    // Size decode, lane shift and strobe generation for the incoming request
    always_comb begin
        byte_mask = '0;
        f3_ok     = 1'b1;
        case (Req_Funct3)
            3'b000:  byte_mask = 4'b0001;
            3'b001:  byte_mask = 4'b0011;
            3'b010:  byte_mask = 4'b1111;
            default: f3_ok     = 1'b0;
        endcase
        masked = '0;
        for (int i = 0; i < int'(NB); i++) begin
            masked[8*i +: 8] = byte_mask[i] ? Req_Data[8*i +: 8] : 8'h00;
        end
        shifted = {{DATA_WIDTH{1'b0}}, masked} << {Req_Addr[1:0], 3'b000};
        strobe8 = {{NB{1'b0}}, byte_mask} << Req_Addr[1:0];
        lo_addr = {Req_Addr[DATA_WIDTH-1:2], 2'b00};
        split   = |strobe8[2*NB-1:NB];
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        hi_strb_d = hi_strb_q;
        hi_pend_d = hi_pend_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req_Valid) begin
                    if (!f3_ok || (!ALLOW_MISALIGNED && split)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = S_SEND_LO;
                        valid_d   = 1'b1;
                        addr_d    = lo_addr;
                        data_d    = shifted[DATA_WIDTH-1:0];
                        strb_d    = strobe8[NB-1:0];
                        hi_addr_d = lo_addr + DATA_WIDTH'(4);
                        hi_data_d = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_strb_d = strobe8[2*NB-1:NB];
                        hi_pend_d = split;
                    end
                end
            end
            S_SEND_LO: begin
                if (Mem_W_Ready) begin
                    if (hi_pend_q) begin
                        // Present the high beat next cycle without dropping valid
                        state_d   = S_SEND_HI;
                        addr_d    = hi_addr_q;
                        data_d    = hi_data_q;
                        strb_d    = hi_strb_q;
                        hi_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        strb_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND_HI: begin
                if (Mem_W_Ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    strb_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                valid_d   = 1'b0;
                addr_d    = '0;
                data_d    = '0;
                strb_d    = '0;
                hi_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
            hi_strb_q <= '0;
            hi_pend_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            hi_strb_q <= hi_strb_d;
            hi_pend_q <= hi_pend_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign Req_Ready   = (state_q == S_IDLE);
    assign Mem_W_Valid = valid_q;
    assign Mem_W_Addr  = addr_q;
    assign Mem_W_Data  = data_q;
    assign Mem_W_Strb  = strb_q;
    assign Store_Done  = done_q;
    assign Store_Err   = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: one instance allows misaligned splits, one rejects them.
module tb_store_align_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        s_req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_ready;

    logic        req_ready,   s_req_ready;
    logic        w_valid,     s_w_valid;
    logic [31:0] w_addr,      s_w_addr;
    logic [31:0] w_data,      s_w_data;
    logic [3:0]  w_strb,      s_w_strb;
    logic        done,        s_done;
    logic        err,         s_err;

    int total;
    int bad;

    store_align_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Req_Funct3(req_funct3), .Req_Addr(req_addr), .Req_Data(req_data),
        .Mem_W_Valid(w_valid), .Mem_W_Ready(mem_ready),
        .Mem_W_Addr(w_addr), .Mem_W_Data(w_data), .Mem_W_Strb(w_strb),
        .Store_Done(done), .Store_Err(err)
    );

    store_align_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_strict (
        .clk(clk), .rst(rst),
        .Req_Valid(s_req_valid), .Req_Ready(s_req_ready),
        .Req_Funct3(req_funct3), .Req_Addr(req_addr), .Req_Data(req_data),
        .Mem_W_Valid(s_w_valid), .Mem_W_Ready(mem_ready),
        .Mem_W_Addr(s_w_addr), .Mem_W_Data(s_w_data), .Mem_W_Strb(s_w_strb),
        .Store_Done(s_done), .Store_Err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request to the main instance for one edge; returns #1 after acceptance
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk({tag, ".valid"}, 64'(w_valid), 64'd1);
        chk({tag, ".addr"},  64'(w_addr),  64'(a));
        chk({tag, ".data"},  64'(w_data),  64'(d));
        chk({tag, ".strb"},  64'(w_strb),  64'(s));
    endtask

    task automatic idle_out(input string tag);
        chk({tag, ".valid"}, 64'(w_valid), 64'd0);
        chk({tag, ".addr"},  64'(w_addr),  64'd0);
        chk({tag, ".data"},  64'(w_data),  64'd0);
        chk({tag, ".strb"},  64'(w_strb),  64'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        s_req_valid = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = '0;
        req_data    = '0;
        mem_ready   = 1'b1;
        #12;
        rst = 1'b0;
        #1;
        idle_out("rst");
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.done",  64'(done),      64'd0);
        chk("rst.err",   64'(err),       64'd0);

        // 1: SB to byte 3
        send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        beat("t1", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        chk("t1.ready_busy", 64'(req_ready), 64'd0);
        chk("t1.done_early", 64'(done), 64'd0);
        step();
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.ready", 64'(req_ready), 64'd1);
        idle_out("t1.idle");
        step();
        chk("t1.done_pulse", 64'(done), 64'd0);

        // 2: SH split across words
        send(3'b001, 32'h0000_2003, 32'h0000_1234);
        beat("t2.lo", 32'h0000_2000, 32'h3400_0000, 4'b1000);
        step();
        beat("t2.hi", 32'h0000_2004, 32'h0000_0012, 4'b0001);
        chk("t2.done_mid", 64'(done), 64'd0);
        step();
        chk("t2.done", 64'(done), 64'd1);
        idle_out("t2.idle");

        // 3: SW with memory stalled three cycles
        mem_ready = 1'b0;
        send(3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
        beat("t3.c1", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step();
            beat("t3.hold", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
            chk("t3.ready", 64'(req_ready), 64'd0);
        end
        mem_ready = 1'b1;
        step();
        chk("t3.done", 64'(done), 64'd1);
        chk("t3.ready_after", 64'(req_ready), 64'd1);
        idle_out("t3.idle");

        // 4: misaligned SW rejected by strict instance, split by permissive one
        req_funct3  = 3'b010;
        req_addr    = 32'h0000_4002;
        req_data    = 32'hDEAD_BEEF;
        s_req_valid = 1'b1;
        step();
        s_req_valid = 1'b0;
        chk("t4.s_err", 64'(s_err), 64'd1);
        chk("t4.s_valid", 64'(s_w_valid), 64'd0);
        chk("t4.s_ready", 64'(s_req_ready), 64'd1);
        step();
        chk("t4.s_err_pulse", 64'(s_err), 64'd0);
        chk("t4.s_valid2", 64'(s_w_valid), 64'd0);
        chk("t4.s_done", 64'(s_done), 64'd0);
        req_addr    = 32'h0000_5000;
        s_req_valid = 1'b1;
        step();
        s_req_valid = 1'b0;
        chk("t4.s_aligned_valid", 64'(s_w_valid), 64'd1);
        chk("t4.s_aligned_strb", 64'(s_w_strb), 64'hF);
        chk("t4.s_aligned_err", 64'(s_err), 64'd0);
        step();
        chk("t4.s_aligned_done", 64'(s_done), 64'd1);
        send(3'b010, 32'h0000_4002, 32'hDEAD_BEEF);
        beat("t4.lo", 32'h0000_4000, 32'hBEEF_0000, 4'b1100);
        chk("t4.err", 64'(err), 64'd0);
        step();
        beat("t4.hi", 32'h0000_4004, 32'h0000_DEAD, 4'b0011);
        step();
        chk("t4.done", 64'(done), 64'd1);

        // 5: illegal funct3, then wrap-around split
        send(3'b011, 32'h0000_5000, 32'h1111_1111);
        chk("t5.err", 64'(err), 64'd1);
        chk("t5.ready", 64'(req_ready), 64'd1);
        idle_out("t5.nobeat");
        step();
        chk("t5.err_pulse", 64'(err), 64'd0);
        chk("t5.no_done", 64'(done), 64'd0);
        chk("t5.valid2", 64'(w_valid), 64'd0);
        send(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
        beat("t5.lo", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        step();
        beat("t5.hi", 32'h0000_0000, 32'h0000_1122, 4'b0011);
        step();
        chk("t5.done", 64'(done), 64'd1);

        // 6: reset asserted during the high beat
        send(3'b010, 32'h0000_6001, 32'hCAFE_F00D);
        beat("t6.lo", 32'h0000_6000, 32'hFE_F00D00, 4'b1110);
        step();
        beat("t6.hi", 32'h0000_6004, 32'h0000_00CA, 4'b0001);
        rst = 1'b1;
        #1;
        idle_out("t6.rst");
        chk("t6.rst_done", 64'(done), 64'd0);
        step();
        #2;
        rst = 1'b0;
        step();
        chk("t6.no_done", 64'(done), 64'd0);
        chk("t6.ready", 64'(req_ready), 64'd1);
        idle_out("t6.idle");
        send(3'b000, 32'h0000_0000, 32'h1234_5655);
        beat("t6.sb", 32'h0000_0000, 32'h0000_0055, 4'b0001);
        step();
        chk("t6.sb_done", 64'(done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart of the load data unit. Sits between the MEM stage and the data-memory write port.
- Takes SB/SH/SW requests and places the store data into the correct byte lanes of a 32-bit word. It also generates the byte strobes.
- A store that crosses a word boundary is split into two word-aligned write beats.
- Uses a valid/ready handshake on both sides, so the pipeline can stall on a slow memory.

Parameters:
- DATA_WIDTH, 32, data and address width. Only 32 is supported; lanes are fixed at 4 bytes.
- ALLOW_MISALIGNED, 1. When 1, boundary-crossing stores are split into two beats. When 0, they are rejected with Store_Err.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- Req_Valid  input  1  a store request is present.
- Req_Ready  output  1  the unit accepts a request this cycle.
- Req_Funct3  input  3  store type: 000 SB, 001 SH, 010 SW.
- Req_Addr  input  32  byte address.
- Req_Data  input  32  rs2 value; the low bytes are used.
- Mem_W_Valid  output  1  a write beat is presented to memory.
- Mem_W_Ready  input  1  memory accepts the beat.
- Mem_W_Addr  output  32  word-aligned address; bits [1:0] are always 00.
- Mem_W_Data  output  32  lane-aligned write data.
- Mem_W_Strb  output  4  byte enables; bit i enables bits [8i+7:8i].
- Store_Done  output  1  one-cycle pulse when a store has fully completed.
- Store_Err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- States: IDLE, SEND_LO, SEND_HI.
- Req_Ready is 1 exactly when state is IDLE. A request is accepted on a rising edge where Req_Valid and Req_Ready are both 1.
- Beat computation at acceptance:
  - off = Req_Addr[1:0].
  - Byte mask m is 0001 for SB, 0011 for SH, 1111 for SW.
  - The data is masked to its size and zero-extended to 64 bits, then shifted left by 8*off.
  - The 8-bit strobe is m shifted left by off.
  - Low beat: address {Req_Addr[31:2],2'b00}, data = shifted[31:0], strobes = strobe[3:0].
  - High beat: address = low address + 4 (wraps modulo 2^32), data = shifted[63:32], strobes = strobe[7:4].
  - A high beat exists only when strobe[7:4] is nonzero.
  - Both beats are registered at acceptance.
- Invalid Funct3 (anything other than 000, 001 or 010):
  - Store_Err pulses in the cycle after acceptance.
  - No beat is issued and state stays IDLE.
- ALLOW_MISALIGNED=0 with a nonzero high strobe: same as invalid Funct3 (Store_Err pulse, no beat). Aligned stores are unaffected.
- IDLE → SEND_LO on a valid accepted request. Mem_W_Valid rises the cycle after acceptance.
- SEND_LO / SEND_HI:
  - Mem_W_Valid is held at 1 and the beat outputs are held stable until Mem_W_Ready=1 at a clock edge.
  - No combinational path from Mem_W_Ready to Mem_W_Valid or to the beat outputs.
- SEND_LO handshake:
  - With a high beat pending: go to SEND_HI and present the high beat next cycle. No idle gap; Mem_W_Valid stays 1.
  - Otherwise: go to IDLE.
- SEND_HI handshake: go to IDLE.
- Completion: Store_Done pulses for one cycle, in the first IDLE cycle after the final handshake. Req_Ready is also 1 in that same cycle, so back-to-back stores run with one bubble cycle.
- Latency:
  - Aligned store with memory always ready: accept at edge N, beat handshake at edge N+1, Store_Done in cycle N+2.
  - Split store: one cycle longer.
- Idle outputs: when not in SEND_*, Mem_W_Valid=0, Mem_W_Strb=0, Mem_W_Addr=0, Mem_W_Data=0.
- Reset (asynchronous, takes effect at any time including mid-store):
  - State returns to IDLE.
  - All outputs are cleared: Mem_W_Valid=0, Mem_W_Addr=0, Mem_W_Data=0, Mem_W_Strb=0, Store_Done=0, Store_Err=0.
  - Req_Ready=1 once rst deasserts.
  - Any pending beat is discarded and no Store_Done is generated for it.
- Req_Valid while busy: ignored (Req_Ready=0). The requester holds its request.

Test Plan:
1. SB, Addr=0x1003, Data=0xAABBCCDD, Mem_W_Ready=1 → one beat: Addr 0x1000, Data 0xDD000000, Strb 1000. Store_Done 2 cycles after accept.
2. SH, Addr=0x2003, Data=0x00001234 → beat 1: 0x2000, Data 0x34000000, Strb 1000. Beat 2: 0x2004, Data 0x00000012, Strb 0001. One Store_Done, after beat 2.
3. SW, Addr=0x3000, Data=0xDEADBEEF, Mem_W_Ready low 3 cycles → Mem_W_Valid and outputs stable for 3 cycles, Strb 1111. Handshake on cycle 4; Req_Ready stays 0 until then.
4. SW, Addr=0x4002, ALLOW_MISALIGNED=0 → Store_Err pulse, Mem_W_Valid never asserted. Same request with ALLOW_MISALIGNED=1 → beats 0x4000/BEEF0000/1100 then 0x4004/0000DEAD/0011.
5. Funct3=011 → Store_Err pulse, no beat. Then SW to 0xFFFFFFFE → second beat at Addr 0x00000000 (wrap).
6. Assert rst while in SEND_HI → outputs clear immediately, no Store_Done. After rst deasserts, a new SB to 0x0 completes normally.
